// File: rtl/alu_iq.sv
// Integer ALU issue queue: age-ordered, compressed entries with per-bank PRF wakeup
// and oldest-ready select feeding the ALU pipeline and its register-read requests.

package core_types_pkg;
    localparam int LOG_PR_COUNT       = 6;
    localparam int LOG_ROB_ENTRIES    = 6;
    localparam int PRF_BANK_COUNT     = 4;
    localparam int LOG_PRF_BANK_COUNT = 2;
endpackage

module alu_iq
    import core_types_pkg::*;
#(
    parameter int ALU_IQ_ENTRIES = 4
) (
    input  logic                                          CLK,
    input  logic                                          nRST,

    input  logic                                          dispatch_valid,
    input  logic [3:0]                                    dispatch_op,
    input  logic                                          dispatch_is_imm,
    input  logic [31:0]                                   dispatch_imm,
    input  logic                                          dispatch_A_unneeded,
    input  logic [LOG_PR_COUNT-1:0]                       dispatch_A_PR,
    input  logic                                          dispatch_A_ready,
    input  logic [LOG_PR_COUNT-1:0]                       dispatch_B_PR,
    input  logic                                          dispatch_B_ready,
    input  logic [LOG_PR_COUNT-1:0]                       dispatch_dest_PR,
    input  logic [LOG_ROB_ENTRIES-1:0]                    dispatch_ROB_index,
    output logic                                          dispatch_ack,

    input  logic [PRF_BANK_COUNT-1:0]                     wakeup_valid_by_bank,
    input  logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-1:0]   wakeup_PR_by_bank,

    output logic                                          issue_valid,
    output logic [3:0]                                    issue_op,
    output logic                                          issue_is_imm,
    output logic [31:0]                                   issue_imm,
    output logic                                          issue_A_unneeded,
    output logic                                          issue_A_forward,
    output logic [LOG_PRF_BANK_COUNT-1:0]                 issue_A_bank,
    output logic                                          issue_B_forward,
    output logic [LOG_PRF_BANK_COUNT-1:0]                 issue_B_bank,
    output logic [LOG_PR_COUNT-1:0]                       issue_dest_PR,
    output logic [LOG_ROB_ENTRIES-1:0]                    issue_ROB_index,
    input  logic                                          issue_ready,

    output logic                                          PRF_req_A_valid,
    output logic [LOG_PR_COUNT-1:0]                       PRF_req_A_PR,
    output logic                                          PRF_req_B_valid,
    output logic [LOG_PR_COUNT-1:0]                       PRF_req_B_PR
);

    // Handshakes: dispatch transfers when dispatch_valid & dispatch_ack; issue transfers
    // when issue_valid & issue_ready. issue_valid never depends on issue_ready.

    localparam int IDX_W = $clog2(ALU_IQ_ENTRIES);

    typedef struct packed {
        logic                       valid;
        logic [3:0]                 op;
        logic                       is_imm;
        logic [31:0]                imm;
        logic                       A_unneeded;
        logic [LOG_PR_COUNT-1:0]    A_PR;
        logic                       A_ready;
        logic [LOG_PR_COUNT-1:0]    B_PR;
        logic                       B_ready;
        logic [LOG_PR_COUNT-1:0]    dest_PR;
        logic [LOG_ROB_ENTRIES-1:0] ROB_index;
    } entry_t;

    entry_t                    entries_q [ALU_IQ_ENTRIES];
    entry_t                    entries_d [ALU_IQ_ENTRIES];
    entry_t                    upd       [ALU_IQ_ENTRIES];
    entry_t                    sel;
    entry_t                    new_entry;
    logic [ALU_IQ_ENTRIES-1:0] A_woken;
    logic [ALU_IQ_ENTRIES-1:0] B_woken;
    logic [ALU_IQ_ENTRIES-1:0] issuable;
    logic [IDX_W-1:0]          sel_idx;
    logic                      sel_A_woken;
    logic                      sel_B_woken;
    logic                      fire;
    logic                      placed;

    // A PR can only be announced on the bank its low bits select.
    function automatic logic pr_woken(
        input logic [LOG_PR_COUNT-1:0]                     pr,
        input logic [PRF_BANK_COUNT-1:0]                   wv,
        input logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-1:0] wpr
    );
        logic [LOG_PRF_BANK_COUNT-1:0] bank;
        bank = pr[LOG_PRF_BANK_COUNT-1:0];
        return wv[bank] && (wpr[bank] == pr);
    endfunction

    always_comb begin
        A_woken  = '0;
        B_woken  = '0;
        issuable = '0;
        for (int i = 0; i < ALU_IQ_ENTRIES; i++) begin
            A_woken[i]  = pr_woken(entries_q[i].A_PR, wakeup_valid_by_bank, wakeup_PR_by_bank);
            B_woken[i]  = pr_woken(entries_q[i].B_PR, wakeup_valid_by_bank, wakeup_PR_by_bank);
            issuable[i] = entries_q[i].valid
                        & (entries_q[i].A_unneeded | entries_q[i].A_ready | A_woken[i])
                        & (entries_q[i].is_imm     | entries_q[i].B_ready | B_woken[i]);
        end
    end

    // Scan from the top so the lowest (oldest) issuable index wins.
    always_comb begin
        sel_idx = '0;
        for (int i = ALU_IQ_ENTRIES - 1; i >= 0; i--) begin
            if (issuable[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    assign sel         = entries_q[sel_idx];
    assign sel_A_woken = A_woken[sel_idx];
    assign sel_B_woken = B_woken[sel_idx];
    assign issue_valid = |issuable;
    assign fire        = issue_valid & issue_ready;

    assign issue_op         = sel.op;
    assign issue_is_imm     = sel.is_imm;
    assign issue_imm        = sel.imm;
    assign issue_A_unneeded = sel.A_unneeded;
    assign issue_A_forward  = issue_valid & sel_A_woken & ~sel.A_ready & ~sel.A_unneeded;
    assign issue_B_forward  = issue_valid & sel_B_woken & ~sel.B_ready & ~sel.is_imm;
    assign issue_A_bank     = sel.A_PR[LOG_PRF_BANK_COUNT-1:0];
    assign issue_B_bank     = sel.B_PR[LOG_PRF_BANK_COUNT-1:0];
    assign issue_dest_PR    = sel.dest_PR;
    assign issue_ROB_index  = sel.ROB_index;

    // Full is judged before this cycle's issue: no issue-to-dispatch bypass.
    assign dispatch_ack = dispatch_valid & ~entries_q[ALU_IQ_ENTRIES-1].valid;

    always_comb begin
        for (int i = 0; i < ALU_IQ_ENTRIES; i++) begin
            upd[i]         = entries_q[i];
            upd[i].A_ready = entries_q[i].A_ready | (entries_q[i].valid & A_woken[i]);
            upd[i].B_ready = entries_q[i].B_ready | (entries_q[i].valid & B_woken[i]);
        end

        // Compress over the issued slot; the top slot always empties on an issue.
        for (int i = 0; i < ALU_IQ_ENTRIES - 1; i++) begin
            entries_d[i] = (fire && (IDX_W'(i) >= sel_idx)) ? upd[i+1] : upd[i];
        end
        entries_d[ALU_IQ_ENTRIES-1] = fire ? '0 : upd[ALU_IQ_ENTRIES-1];

        new_entry            = '0;
        new_entry.valid      = 1'b1;
        new_entry.op         = dispatch_op;
        new_entry.is_imm     = dispatch_is_imm;
        new_entry.imm        = dispatch_imm;
        new_entry.A_unneeded = dispatch_A_unneeded;
        new_entry.A_PR       = dispatch_A_PR;
        new_entry.A_ready    = dispatch_A_ready
                             | pr_woken(dispatch_A_PR, wakeup_valid_by_bank, wakeup_PR_by_bank);
        new_entry.B_PR       = dispatch_B_PR;
        new_entry.B_ready    = dispatch_B_ready
                             | pr_woken(dispatch_B_PR, wakeup_valid_by_bank, wakeup_PR_by_bank);
        new_entry.dest_PR    = dispatch_dest_PR;
        new_entry.ROB_index  = dispatch_ROB_index;

        placed = 1'b0;
        for (int i = 0; i < ALU_IQ_ENTRIES; i++) begin
            if (dispatch_ack && !placed && !entries_d[i].valid) begin
                entries_d[i] = new_entry;
                placed       = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < ALU_IQ_ENTRIES; i++) begin
                entries_q[i] <= '0;
            end
            PRF_req_A_valid <= 1'b0;
            PRF_req_A_PR    <= '0;
            PRF_req_B_valid <= 1'b0;
            PRF_req_B_PR    <= '0;
        end else begin
            for (int i = 0; i < ALU_IQ_ENTRIES; i++) begin
                entries_q[i] <= entries_d[i];
            end
            // Forwarded operands bypass the PRF, so only stored-ready ones are read.
            PRF_req_A_valid <= fire & ~sel.A_unneeded & sel.A_ready;
            PRF_req_A_PR    <= sel.A_PR;
            PRF_req_B_valid <= fire & ~sel.is_imm & sel.B_ready;
            PRF_req_B_PR    <= sel.B_PR;
        end
    end

endmodule

// File: tb/tb_alu_iq.sv
// Directed bench for alu_iq: single-op vector table plus hand-written
// sequences for full queue, out-of-order select, issue+dispatch and mid-run reset.

module tb_alu_iq;
    import core_types_pkg::*;

    logic                                        CLK;
    logic                                        nRST;
    logic                                        dispatch_valid;
    logic [3:0]                                  dispatch_op;
    logic                                        dispatch_is_imm;
    logic [31:0]                                 dispatch_imm;
    logic                                        dispatch_A_unneeded;
    logic [LOG_PR_COUNT-1:0]                     dispatch_A_PR;
    logic                                        dispatch_A_ready;
    logic [LOG_PR_COUNT-1:0]                     dispatch_B_PR;
    logic                                        dispatch_B_ready;
    logic [LOG_PR_COUNT-1:0]                     dispatch_dest_PR;
    logic [LOG_ROB_ENTRIES-1:0]                  dispatch_ROB_index;
    logic                                        dispatch_ack;
    logic [PRF_BANK_COUNT-1:0]                   wakeup_valid_by_bank;
    logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-1:0] wakeup_PR_by_bank;
    logic                                        issue_valid;
    logic [3:0]                                  issue_op;
    logic                                        issue_is_imm;
    logic [31:0]                                 issue_imm;
    logic                                        issue_A_unneeded;
    logic                                        issue_A_forward;
    logic [LOG_PRF_BANK_COUNT-1:0]               issue_A_bank;
    logic                                        issue_B_forward;
    logic [LOG_PRF_BANK_COUNT-1:0]               issue_B_bank;
    logic [LOG_PR_COUNT-1:0]                     issue_dest_PR;
    logic [LOG_ROB_ENTRIES-1:0]                  issue_ROB_index;
    logic                                        issue_ready;
    logic                                        PRF_req_A_valid;
    logic [LOG_PR_COUNT-1:0]                     PRF_req_A_PR;
    logic                                        PRF_req_B_valid;
    logic [LOG_PR_COUNT-1:0]                     PRF_req_B_PR;

    int checks = 0;
    int errors = 0;
    logic [LOG_ROB_ENTRIES-1:0] exp_q[$];

    alu_iq #(.ALU_IQ_ENTRIES(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .dispatch_valid(dispatch_valid), .dispatch_op(dispatch_op),
        .dispatch_is_imm(dispatch_is_imm), .dispatch_imm(dispatch_imm),
        .dispatch_A_unneeded(dispatch_A_unneeded), .dispatch_A_PR(dispatch_A_PR),
        .dispatch_A_ready(dispatch_A_ready), .dispatch_B_PR(dispatch_B_PR),
        .dispatch_B_ready(dispatch_B_ready), .dispatch_dest_PR(dispatch_dest_PR),
        .dispatch_ROB_index(dispatch_ROB_index), .dispatch_ack(dispatch_ack),
        .wakeup_valid_by_bank(wakeup_valid_by_bank), .wakeup_PR_by_bank(wakeup_PR_by_bank),
        .issue_valid(issue_valid), .issue_op(issue_op), .issue_is_imm(issue_is_imm),
        .issue_imm(issue_imm), .issue_A_unneeded(issue_A_unneeded),
        .issue_A_forward(issue_A_forward), .issue_A_bank(issue_A_bank),
        .issue_B_forward(issue_B_forward), .issue_B_bank(issue_B_bank),
        .issue_dest_PR(issue_dest_PR), .issue_ROB_index(issue_ROB_index),
        .issue_ready(issue_ready),
        .PRF_req_A_valid(PRF_req_A_valid), .PRF_req_A_PR(PRF_req_A_PR),
        .PRF_req_B_valid(PRF_req_B_valid), .PRF_req_B_PR(PRF_req_B_PR)
    );

    // Clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string                   name;
        logic [3:0]              op;
        logic                    is_imm;
        logic [31:0]             imm;
        logic                    a_unneeded;
        logic [LOG_PR_COUNT-1:0] a_pr;
        logic                    a_ready;
        logic [LOG_PR_COUNT-1:0] b_pr;
        logic                    b_ready;
        logic                    wa_en;
        logic [LOG_PR_COUNT-1:0] wa_pr;
        logic                    wb_en;
        logic [LOG_PR_COUNT-1:0] wb_pr;
        logic                    exp_iv;
        logic                    exp_fa;
        logic                    exp_fb;
        logic                    exp_pa;
        logic                    exp_pb;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic clear_inputs();
        dispatch_valid       = 1'b0;
        dispatch_op          = '0;
        dispatch_is_imm      = 1'b0;
        dispatch_imm         = '0;
        dispatch_A_unneeded  = 1'b0;
        dispatch_A_PR        = '0;
        dispatch_A_ready     = 1'b0;
        dispatch_B_PR        = '0;
        dispatch_B_ready     = 1'b0;
        dispatch_dest_PR     = '0;
        dispatch_ROB_index   = '0;
        wakeup_valid_by_bank = '0;
        wakeup_PR_by_bank    = '0;
        issue_ready          = 1'b0;
    endtask

    task automatic set_wake(input logic a_en, input logic [LOG_PR_COUNT-1:0] a_pr,
                            input logic b_en, input logic [LOG_PR_COUNT-1:0] b_pr);
        wakeup_valid_by_bank = '0;
        wakeup_PR_by_bank    = '0;
        if (a_en) begin
            wakeup_valid_by_bank[a_pr % PRF_BANK_COUNT] = 1'b1;
            wakeup_PR_by_bank[a_pr % PRF_BANK_COUNT]    = a_pr;
        end
        if (b_en) begin
            wakeup_valid_by_bank[b_pr % PRF_BANK_COUNT] = 1'b1;
            wakeup_PR_by_bank[b_pr % PRF_BANK_COUNT]    = b_pr;
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        nRST = 1'b0;
        clear_inputs();
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    // Simple register-register op; B is always ready.
    task automatic dispatch_simple(input logic [LOG_ROB_ENTRIES-1:0] rob,
                                   input logic [LOG_PR_COUNT-1:0] a_pr, input logic a_ready);
        dispatch_valid      = 1'b1;
        dispatch_op         = 4'd1;
        dispatch_is_imm     = 1'b0;
        dispatch_imm        = '0;
        dispatch_A_unneeded = 1'b0;
        dispatch_A_PR       = a_pr;
        dispatch_A_ready    = a_ready;
        dispatch_B_PR       = a_pr + 6'd1;
        dispatch_B_ready    = 1'b1;
        dispatch_dest_PR    = LOG_PR_COUNT'(rob) + 6'd16;
        dispatch_ROB_index  = rob;
    endtask

    task automatic drain(input string name, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge CLK);
            dispatch_valid = 1'b0;
            issue_ready    = 1'b1;
            #1;
            check({name, "_valid"}, 32'(issue_valid), 32'd1);
            if (exp_q.size() > 0) check({name, "_rob"}, 32'(issue_ROB_index), 32'(exp_q.pop_front()));
        end
        @(negedge CLK);
        issue_ready = 1'b0;
        #1;
        check({name, "_empty"}, 32'(issue_valid), 32'd0);
    endtask

    initial begin
        vecs[0] = '{"v_both_ready", 4'd0, 1'b0, 32'h0,        1'b0, 6'd1,  1'b1, 6'd2,  1'b1,
                    1'b0, 6'd0,  1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{"v_wake_a",     4'd3, 1'b0, 32'h0,        1'b0, 6'd5,  1'b0, 6'd6,  1'b1,
                    1'b1, 6'd5,  1'b0, 6'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{"v_imm",        4'd7, 1'b1, 32'hDEADBEEF, 1'b0, 6'd9,  1'b1, 6'd10, 1'b0,
                    1'b0, 6'd0,  1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{"v_a_unneeded", 4'd2, 1'b0, 32'h0,        1'b1, 6'd3,  1'b0, 6'd12, 1'b0,
                    1'b0, 6'd0,  1'b1, 6'd12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{"v_wrong_pr",   4'd4, 1'b0, 32'h0,        1'b0, 6'd7,  1'b0, 6'd15, 1'b1,
                    1'b1, 6'd11, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{"v_wake_both",  4'd5, 1'b0, 32'h0,        1'b0, 6'd13, 1'b0, 6'd14, 1'b0,
                    1'b1, 6'd13, 1'b1, 6'd14, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{"v_same_bank",  4'd6, 1'b0, 32'h0,        1'b0, 6'd4,  1'b0, 6'd8,  1'b0,
                    1'b0, 6'd0,  1'b1, 6'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset state, with dispatch_valid high during reset
        nRST = 1'b0;
        clear_inputs();
        dispatch_valid = 1'b1;
        #2;
        check("rst_issue_valid", 32'(issue_valid), 32'd0);
        check("rst_ack_follows", 32'(dispatch_ack), 32'd1);
        check("rst_preq_a", 32'(PRF_req_A_valid), 32'd0);
        check("rst_preq_b", 32'(PRF_req_B_valid), 32'd0);

        // Single-op vector table
        for (int v = 0; v < 7; v++) begin
            do_reset();
            dispatch_valid      = 1'b1;
            dispatch_op         = vecs[v].op;
            dispatch_is_imm     = vecs[v].is_imm;
            dispatch_imm        = vecs[v].imm;
            dispatch_A_unneeded = vecs[v].a_unneeded;
            dispatch_A_PR       = vecs[v].a_pr;
            dispatch_A_ready    = vecs[v].a_ready;
            dispatch_B_PR       = vecs[v].b_pr;
            dispatch_B_ready    = vecs[v].b_ready;
            dispatch_dest_PR    = 6'(32 + v);
            dispatch_ROB_index  = 6'(v);
            #1;
            check({vecs[v].name, "_ack"}, 32'(dispatch_ack), 32'd1);
            check({vecs[v].name, "_no_bypass"}, 32'(issue_valid), 32'd0);

            @(negedge CLK);
            dispatch_valid = 1'b0;
            issue_ready    = 1'b1;
            set_wake(vecs[v].wa_en, vecs[v].wa_pr, vecs[v].wb_en, vecs[v].wb_pr);
            #1;
            check({vecs[v].name, "_iv"}, 32'(issue_valid), 32'(vecs[v].exp_iv));
            if (vecs[v].exp_iv) begin
                check({vecs[v].name, "_fa"}, 32'(issue_A_forward), 32'(vecs[v].exp_fa));
                check({vecs[v].name, "_fb"}, 32'(issue_B_forward), 32'(vecs[v].exp_fb));
                check({vecs[v].name, "_op"}, 32'(issue_op), 32'(vecs[v].op));
                check({vecs[v].name, "_imm"}, issue_imm, vecs[v].imm);
                check({vecs[v].name, "_is_imm"}, 32'(issue_is_imm), 32'(vecs[v].is_imm));
                check({vecs[v].name, "_a_unn"}, 32'(issue_A_unneeded), 32'(vecs[v].a_unneeded));
                check({vecs[v].name, "_dest"}, 32'(issue_dest_PR), 32 + v);
                check({vecs[v].name, "_rob"}, 32'(issue_ROB_index), 32'(v));
                check({vecs[v].name, "_a_bank"}, 32'(issue_A_bank), 32'(vecs[v].a_pr % PRF_BANK_COUNT));
                check({vecs[v].name, "_b_bank"}, 32'(issue_B_bank), 32'(vecs[v].b_pr % PRF_BANK_COUNT));
            end

            @(negedge CLK);
            set_wake(1'b0, '0, 1'b0, '0);
            issue_ready = 1'b0;
            #1;
            check({vecs[v].name, "_preq_a"}, 32'(PRF_req_A_valid), 32'(vecs[v].exp_pa));
            check({vecs[v].name, "_preq_b"}, 32'(PRF_req_B_valid), 32'(vecs[v].exp_pb));
            if (vecs[v].exp_pa) check({vecs[v].name, "_preq_a_pr"}, 32'(PRF_req_A_PR), 32'(vecs[v].a_pr));
            if (vecs[v].exp_pb) check({vecs[v].name, "_preq_b_pr"}, 32'(PRF_req_B_PR), 32'(vecs[v].b_pr));
            check({vecs[v].name, "_gone"}, 32'(issue_valid), 32'd0);
        end

        // Full queue: fifth dispatch refused even while the head issues
        do_reset();
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge CLK);
            dispatch_simple(6'(k), 6'(2 * k), 1'b1);
            #1;
            check("full_fill_ack", 32'(dispatch_ack), 32'd1);
        end
        @(negedge CLK);
        dispatch_simple(6'd8, 6'd40, 1'b1);
        issue_ready = 1'b1;
        #1;
        check("full_ack_low", 32'(dispatch_ack), 32'd0);
        check("full_head_rob", 32'(issue_ROB_index), 32'd0);
        @(negedge CLK);
        dispatch_simple(6'd9, 6'd42, 1'b1);
        issue_ready = 1'b0;
        #1;
        check("full_ack_after_issue", 32'(dispatch_ack), 32'd1);
        check("full_new_head", 32'(issue_ROB_index), 32'd1);
        exp_q = '{6'd1, 6'd2, 6'd3, 6'd9};
        drain("full_drain", 4);

        // Younger ready op passes an older waiting one
        do_reset();
        dispatch_simple(6'd10, 6'd20, 1'b0);
        @(negedge CLK);
        dispatch_simple(6'd11, 6'd24, 1'b1);
        @(negedge CLK);
        dispatch_simple(6'd12, 6'd28, 1'b1);
        @(negedge CLK);
        dispatch_valid = 1'b0;
        issue_ready    = 1'b1;
        #1;
        check("ooo_first", 32'(issue_ROB_index), 32'd11);
        @(negedge CLK);
        #1;
        check("ooo_second", 32'(issue_ROB_index), 32'd12);
        @(negedge CLK);
        #1;
        check("ooo_old_waits", 32'(issue_valid), 32'd0);
        @(negedge CLK);
        set_wake(1'b1, 6'd20, 1'b0, '0);
        #1;
        check("ooo_old_woken", 32'(issue_valid), 32'd1);
        check("ooo_old_rob", 32'(issue_ROB_index), 32'd10);
        check("ooo_old_fwd", 32'(issue_A_forward), 32'd1);
        @(negedge CLK);
        set_wake(1'b0, '0, 1'b0, '0);
        issue_ready = 1'b0;
        #1;
        check("ooo_preq_a", 32'(PRF_req_A_valid), 32'd0);
        check("ooo_preq_b", 32'(PRF_req_B_valid), 32'd1);
        check("ooo_empty", 32'(issue_valid), 32'd0);

        // Issue and dispatch together at three occupied
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) @(negedge CLK);
            dispatch_simple(6'(k), 6'(2 * k), 1'b1);
        end
        @(negedge CLK);
        dispatch_simple(6'd4, 6'd50, 1'b1);
        issue_ready = 1'b1;
        #1;
        check("both_ack", 32'(dispatch_ack), 32'd1);
        check("both_issue_rob", 32'(issue_ROB_index), 32'd1);
        @(negedge CLK);
        dispatch_simple(6'd5, 6'd52, 1'b1);
        issue_ready = 1'b0;
        #1;
        check("both_count_three", 32'(dispatch_ack), 32'd1);
        @(negedge CLK);
        dispatch_simple(6'd6, 6'd54, 1'b1);
        #1;
        check("both_now_full", 32'(dispatch_ack), 32'd0);
        exp_q = '{6'd2, 6'd3, 6'd4, 6'd5};
        drain("both_drain", 4);

        // Asynchronous reset with three held entries
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) @(negedge CLK);
            dispatch_simple(6'(k), 6'(2 * k), 1'b1);
        end
        @(negedge CLK);
        dispatch_valid = 1'b0;
        issue_ready    = 1'b1;
        #1;
        check("arst_pre_issue", 32'(issue_ROB_index), 32'd1);
        @(negedge CLK);
        issue_ready = 1'b0;
        #1;
        check("arst_pre_preq", 32'(PRF_req_A_valid), 32'd1);
        check("arst_pre_held", 32'(issue_valid), 32'd1);
        #2;
        nRST = 1'b0;
        dispatch_valid = 1'b1;
        #1;
        check("arst_issue_valid", 32'(issue_valid), 32'd0);
        check("arst_preq_a", 32'(PRF_req_A_valid), 32'd0);
        check("arst_preq_b", 32'(PRF_req_B_valid), 32'd0);
        check("arst_ack", 32'(dispatch_ack), 32'd1);
        dispatch_valid = 1'b0;
        #1;
        check("arst_ack_low", 32'(dispatch_ack), 32'd0);
        @(negedge CLK);
        nRST        = 1'b1;
        issue_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            #1;
            check("arst_no_issue", 32'(issue_valid), 32'd0);
            check("arst_no_preq", 32'(PRF_req_A_valid), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
